pcie_rx_tlp_framer: RTL and testbench
=====================================

Name: pcie_rx_tlp_framer

Overview:
- Receive-side stage directly downstream of the Spartan-6 PCI-E core transaction RX interface, upstream of the MicroBlaze TLP RX stream.
- Store-and-forward: buffers each complete TLP, prepends one header word (BAR hit, poisoned flag, DW count) and emits the frame on a 32-bit AXI-Stream master.
- Never back-pressures the core while the link is up. TLPs that do not fit are dropped whole and counted.

Parameters:
- DEPTH_LOG2, 6, log2 of buffer depth in 32-bit words; buffer holds 2^DEPTH_LOG2 words, header included.

Ports:
- user_clk  in  1  core user clock; the only clock.
- user_reset  in  1  reset.
- user_lnk_up  in  1  link up from core.
- m_axis_rx_tdata  in  32  TLP data from core.
- m_axis_rx_tkeep  in  4  byte enables; ignored (32-bit core always presents full DWs).
- m_axis_rx_tlast  in  1  last beat of TLP.
- m_axis_rx_tvalid  in  1  beat valid.
- m_axis_rx_tready  out  1  beat accept.
- m_axis_rx_tuser  in  22  bit1 = poisoned (err_fwd); bits 9:2 = bar_hit.
- M_AXIS_TDATA  out  32  framed output data.
- M_AXIS_TLAST  out  1  last word of frame.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  consumer ready.
- drop_count  out  16  saturating count of dropped TLPs.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. Clock is user_clk, reset is user_reset.
- Reset values: m_axis_rx_tready=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, drop_count=0. Pointers are cleared and both FSMs go idle.
- Ready: m_axis_rx_tready = user_lnk_up, registered. A beat is accepted when tvalid && tready.
- Storage: circular RAM with pointers of DEPTH_LOG2+1 bits. There are three pointers: wr_ptr (speculative), commit_ptr and rd_ptr. The reader sees only [rd_ptr, commit_ptr).
- Write FSM:
  - W_IDLE: on the first accepted beat, reserve a header slot at wr_ptr, write the beat at wr_ptr+1, set wr_ptr+=2 and len=1. Latch bar_hit and poisoned from tuser of this beat. Go to W_STORE, or to W_COMMIT if tlast.
  - W_STORE: each accepted beat is written at wr_ptr; wr_ptr++, len++. On tlast go to W_COMMIT.
  - W_COMMIT (1 cycle): write header {bar_hit[7:0], 7'b0, poisoned, 5'b0, len[10:0]} into the reserved slot, set commit_ptr=wr_ptr, go to W_IDLE.
  - Header bits: [31:24] bar_hit, [16] poisoned, [10:0] payload DW count.
  - tready stays asserted in W_COMMIT. A beat arriving that cycle starts the next TLP, with its header slot reserved at the new wr_ptr. This gives back-to-back TLPs with no gap.
- Overflow: if an accepted beat would make wr_ptr - rd_ptr exceed 2^DEPTH_LOG2, then:
  - rewind wr_ptr to commit_ptr;
  - increment drop_count, saturating at 16'hFFFF;
  - go to W_DISCARD, or straight to W_IDLE if that beat has tlast.
  - A frame that exactly fills the buffer is accepted.
- W_DISCARD: accept and discard beats until tlast, then go to W_IDLE.
- Link loss: if user_lnk_up=0 while in W_STORE, rewind wr_ptr to commit_ptr and go to W_IDLE. drop_count is not changed. Committed frames still drain.
- Read FSM:
  - R_IDLE: when rd_ptr != commit_ptr, present the header word with TLAST=0, load the remaining count from header[10:0], go to R_DATA.
  - R_DATA: on each handshake, present the next word. TLAST=1 on the word where remaining=1; after that handshake go to R_IDLE.
  - The output register holds data/valid stable while TVALID && !TREADY (AXIS rule).
  - The reader may re-arm in the same cycle as the final handshake if another frame is committed (no bubble required, one allowed).
- Latency: the header word is valid on the 2nd rising edge after the tlast beat is accepted, provided the output is idle.
- Simultaneous read/write: allowed every cycle. The full check uses rd_ptr as registered at the start of the cycle.

Test Plan:
- Single 3-DW MRd TLP, bar_hit=8'h01, poisoned=0 -> output 32'h01000003 then the 3 DWs; TLAST only on the 3rd DW; header valid 2 cycles after input tlast.
- Two back-to-back 4-DW TLPs with no idle cycle, M_AXIS_TREADY=1 -> both frames intact in order; m_axis_rx_tready never deasserts.
- DEPTH_LOG2=4, TREADY=0, 20-DW TLP -> TLP dropped, drop_count=1, no output. Then a 15-DW TLP -> accepted (exact fill), header len=15.
- Poisoned 1-DW TLP (tuser[1]=1, bar_hit=8'h02) -> header 32'h02010001.
- user_lnk_up falls after 2 beats of a 5-DW TLP -> partial discarded, drop_count unchanged; an earlier committed frame still drains fully.
- user_reset asserted mid-output with TREADY toggling -> TVALID/TLAST/TDATA go to 0 immediately, drop_count=0; after release the next TLP frames correctly.

Source files
------------

// File: rtl/pcie_rx_tlp_framer.sv
// rtl/pcie_rx_tlp_framer.sv - store-and-forward TLP framer: buffers whole TLPs, prepends a header word, drops TLPs that do not fit
module pcie_rx_tlp_framer #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        user_lnk_up,
  input  logic [31:0] m_axis_rx_tdata,
  input  logic [3:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready,
  input  logic [21:0] m_axis_rx_tuser,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [15:0] drop_count
);
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_COMMIT, W_DISCARD} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  wstate_t     wstate_q, wstate_d;
  rstate_t     rstate_q, rstate_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] hdr_slot_q, hdr_slot_d;
  logic [10:0] len_q, len_d, rem_q, rem_d;
  logic [7:0]  bar_hit_q, bar_hit_d;
  logic        poisoned_q, poisoned_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        rx_ready_q;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;

  logic          beat, start, drop;
  logic [PW:0]   occ;
  logic          dat_we, hdr_we;
  logic [AW-1:0] dat_addr, hdr_addr;
  logic [31:0]   hdr_data, rd_word;
  logic          unused_inputs;

  assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:10], m_axis_rx_tuser[0]};

  assign beat     = m_axis_rx_tvalid && rx_ready_q;
  assign occ      = {1'b0, wr_ptr_q - rd_ptr_q};
  assign hdr_data = {bar_hit_q, 7'b0, poisoned_q, 5'b0, len_q};
  assign hdr_addr = hdr_slot_q[AW-1:0];
  assign rd_word  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    hdr_slot_d   = hdr_slot_q;
    len_d        = len_q;
    bar_hit_d    = bar_hit_q;
    poisoned_d   = poisoned_q;
    drop_count_d = drop_count_q;
    dat_we       = 1'b0;
    dat_addr     = wr_ptr_q[AW-1:0];
    hdr_we       = 1'b0;
    start        = 1'b0;
    drop         = 1'b0;
    case (wstate_q)
      W_IDLE: start = beat;
      W_COMMIT: begin
        hdr_we       = 1'b1;
        commit_ptr_d = wr_ptr_q;
        wstate_d     = W_IDLE;
        start        = beat;
      end
      W_STORE: begin
        if (!user_lnk_up) begin
          wr_ptr_d = commit_ptr_q;
          wstate_d = W_IDLE;
        end else if (beat) begin
          if (occ + (PW+1)'(1) > (PW+1)'(DEPTH)) begin
            drop     = 1'b1;
            wr_ptr_d = commit_ptr_q;
            wstate_d = m_axis_rx_tlast ? W_IDLE : W_DISCARD;
          end else begin
            dat_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = len_q + 11'd1;
            if (m_axis_rx_tlast) wstate_d = W_COMMIT;
          end
        end
      end
      W_DISCARD: if (beat && m_axis_rx_tlast) wstate_d = W_IDLE;
      default:   wstate_d = W_IDLE;
    endcase
    // A new TLP needs room for its header slot plus its first beat.
    if (start) begin
      if (occ + (PW+1)'(2) > (PW+1)'(DEPTH)) begin
        drop     = 1'b1;
        wstate_d = m_axis_rx_tlast ? W_IDLE : W_DISCARD;
      end else begin
        hdr_slot_d = wr_ptr_q;
        dat_we     = 1'b1;
        dat_addr   = wr_ptr_q[AW-1:0] + AW'(1);
        wr_ptr_d   = wr_ptr_q + PW'(2);
        len_d      = 11'd1;
        bar_hit_d  = m_axis_rx_tuser[9:2];
        poisoned_d = m_axis_rx_tuser[1];
        wstate_d   = m_axis_rx_tlast ? W_COMMIT : W_STORE;
      end
    end
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_comb begin
    rstate_d = rstate_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (rstate_q)
      R_IDLE: begin
        if (rd_ptr_q != commit_ptr_q) begin
          tdata_d  = rd_word;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          rem_d    = rd_word[10:0];
          rd_ptr_d = rd_ptr_q + PW'(1);
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (M_AXIS_TREADY) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            rstate_d = R_IDLE;
          end else begin
            tdata_d  = rd_word;
            tlast_d  = (rem_q == 11'd1);
            rem_d    = rem_q - 11'd1;
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      hdr_slot_q   <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      bar_hit_q    <= '0;
      poisoned_q   <= 1'b0;
      drop_count_q <= '0;
      rx_ready_q   <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hdr_slot_q   <= hdr_slot_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      bar_hit_q    <= bar_hit_d;
      poisoned_q   <= poisoned_d;
      drop_count_q <= drop_count_d;
      rx_ready_q   <= user_lnk_up;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

  // The header write and the next TLP's first beat can land in the same cycle.
  always_ff @(posedge user_clk) begin
    if (dat_we) mem[dat_addr] <= m_axis_rx_tdata;
    if (hdr_we) mem[hdr_addr] <= hdr_data;
  end

  assign m_axis_rx_tready = rx_ready_q;
  assign M_AXIS_TDATA     = tdata_q;
  assign M_AXIS_TVALID    = tvalid_q;
  assign M_AXIS_TLAST     = tlast_q;
  assign drop_count       = drop_count_q;
endmodule

// File: tb/tb_pcie_rx_tlp_framer.sv
// tb/tb_pcie_rx_tlp_framer.sv - scoreboard bench for pcie_rx_tlp_framer
module tb_pcie_rx_tlp_framer;
  localparam int DL2 = 4;
  localparam int BUF_WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        user_reset = 1'b1;
  logic        user_lnk_up = 1'b0;
  logic [31:0] m_axis_rx_tdata = '0;
  logic [3:0]  m_axis_rx_tkeep = '0;
  logic        m_axis_rx_tlast = 1'b0;
  logic        m_axis_rx_tvalid = 1'b0;
  logic        m_axis_rx_tready;
  logic [21:0] m_axis_rx_tuser = '0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [15:0] drop_count;

  pcie_rx_tlp_framer #(.DEPTH_LOG2(DL2)) dut (
    .user_clk(clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
    .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tready(m_axis_rx_tready), .m_axis_rx_tuser(m_axis_rx_tuser),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_drop = 0;
  int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  bit   stall_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=event t=%0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       M_AXIS_TREADY = 1'b0;
      1:       M_AXIS_TREADY = 1'b1;
      default: M_AXIS_TREADY = 1'($urandom);
    endcase
  end

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!user_reset && M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", M_AXIS_TDATA, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_tdata", M_AXIS_TDATA, e.d);
        check("out_tlast", {31'b0, M_AXIS_TLAST}, {31'b0, e.l});
      end
    end
  end

  // Drives one TLP (or its first nsend beats); when keep is set the expected frame is queued.
  task automatic drive_tlp(input int len, input int nsend, input logic [7:0] bar,
                           input bit pois, input bit gaps, input bit keep);
    logic [31:0] d;
    int guard;
    bit acc;
    if (keep)
      exp_q.push_back('{d: (32'(bar) << 24) | (32'(pois) << 16) | 32'(len), l: 1'b0});
    for (int i = 0; i < nsend; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) begin
          m_axis_rx_tvalid = 1'b0;
          tick();
        end
      d = $urandom;
      m_axis_rx_tvalid = 1'b1;
      m_axis_rx_tdata  = d;
      m_axis_rx_tlast  = (i == len - 1);
      m_axis_rx_tuser  = {12'($urandom), bar, pois, 1'($urandom)};
      m_axis_rx_tkeep  = 4'($urandom);
      guard = 0;
      acc = 1'b0;
      while (!acc) begin
        acc = m_axis_rx_tready;
        if (!acc) stall_seen = 1'b1;
        tick();
        guard++;
        if (!acc && guard > 500) begin
          timeout("rx_accept");
          acc = 1'b1;
        end
      end
      if (keep) exp_q.push_back('{d: d, l: (i == len - 1)});
    end
  endtask

  task automatic idle_in();
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tlast  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    tick();
    tick();
    tick();
    while (exp_q.size() != 0 || M_AXIS_TVALID) begin
      tick();
      guard++;
      if (guard > 3000) begin
        timeout("drain");
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int len;
    bit keep;
    #2;
    check("rst_rx_tready", {31'b0, m_axis_rx_tready}, 32'd0);
    check("rst_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    check("rst_tlast", {31'b0, M_AXIS_TLAST}, 32'd0);
    check("rst_tdata", M_AXIS_TDATA, 32'd0);
    check("rst_drop", {16'b0, drop_count}, 32'd0);
    user_lnk_up = 1'b1;
    tick();
    tick();
    user_reset = 1'b0;
    tick();
    tick();
    check("lnk_ready", {31'b0, m_axis_rx_tready}, 32'd1);

    // single 3-DW TLP, header latency
    ready_mode = 1;
    drive_tlp(3, 3, 8'h01, 1'b0, 1'b0, 1'b1);
    idle_in();
    check("lat_e0_valid", {31'b0, M_AXIS_TVALID}, 32'd0);
    tick();
    check("lat_e1_valid", {31'b0, M_AXIS_TVALID}, 32'd0);
    tick();
    check("lat_e2_valid", {31'b0, M_AXIS_TVALID}, 32'd1);
    check("lat_e2_hdr", M_AXIS_TDATA, 32'h01000003);
    drain();

    // back-to-back 4-DW TLPs
    stall_seen = 1'b0;
    drive_tlp(4, 4, 8'h20, 1'b0, 1'b0, 1'b1);
    drive_tlp(4, 4, 8'h40, 1'b0, 1'b0, 1'b1);
    idle_in();
    check("b2b_no_stall", {31'b0, stall_seen}, 32'd0);
    drain();

    // overflow drop, then exact fill
    ready_mode = 0;
    drive_tlp(20, 20, 8'h08, 1'b0, 1'b1, 1'b0);
    idle_in();
    exp_drop++;
    tick();
    tick();
    tick();
    check("ovf_drop", {16'b0, drop_count}, 32'(exp_drop));
    check("ovf_no_out", {31'b0, M_AXIS_TVALID}, 32'd0);
    drive_tlp(15, 15, 8'h10, 1'b0, 1'b1, 1'b1);
    idle_in();
    tick();
    tick();
    tick();
    check("fill_drop", {16'b0, drop_count}, 32'(exp_drop));
    check("fill_valid", {31'b0, M_AXIS_TVALID}, 32'd1);
    check("fill_hdr", M_AXIS_TDATA, 32'h1000000F);
    ready_mode = 1;
    drain();

    // poisoned 1-DW TLP
    drive_tlp(1, 1, 8'h02, 1'b1, 1'b0, 1'b1);
    idle_in();
    tick();
    tick();
    check("pois_hdr", M_AXIS_TDATA, 32'h02010001);
    drain();

    // link loss mid-TLP with a committed frame waiting
    ready_mode = 0;
    drive_tlp(3, 3, 8'h04, 1'b0, 1'b0, 1'b1);
    drive_tlp(5, 2, 8'h05, 1'b0, 1'b0, 1'b0);
    idle_in();
    user_lnk_up = 1'b0;
    tick();
    tick();
    tick();
    check("lnk_drop_same", {16'b0, drop_count}, 32'(exp_drop));
    check("lnk_ready_low", {31'b0, m_axis_rx_tready}, 32'd0);
    user_lnk_up = 1'b1;
    tick();
    tick();
    ready_mode = 1;
    drain();
    drive_tlp(2, 2, 8'h06, 1'b0, 1'b0, 1'b1);
    idle_in();
    drain();

    // randomized TLPs against the occupancy rule
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      len  = $urandom_range(1, 18);
      keep = (len + 1 <= BUF_WORDS);
      if (!keep) exp_drop++;
      drive_tlp(len, len, 8'($urandom), 1'($urandom), 1'b1, keep);
      idle_in();
      drain();
      check("rand_drop", {16'b0, drop_count}, 32'(exp_drop));
    end

    // reset mid-output
    drive_tlp(10, 10, 8'h33, 1'b0, 1'b0, 1'b1);
    idle_in();
    tick();
    tick();
    tick();
    tick();
    #1;
    user_reset = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    check("mid_rst_tlast", {31'b0, M_AXIS_TLAST}, 32'd0);
    check("mid_rst_tdata", M_AXIS_TDATA, 32'd0);
    check("mid_rst_drop", {16'b0, drop_count}, 32'd0);
    exp_q.delete();
    exp_drop = 0;
    tick();
    tick();
    user_reset = 1'b0;
    tick();
    tick();
    drive_tlp(3, 3, 8'h81, 1'b1, 1'b1, 1'b1);
    idle_in();
    drain();
    check("end_drop", {16'b0, drop_count}, 32'(exp_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
